// File: rtl/ibex_stim_phase_ctrl_if.sv
// ibex_stim_phase_ctrl_if: fetch port and random-source handshake between the core side and the phase controller
interface ibex_stim_phase_ctrl_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        rand_valid;
  logic [31:0] rand_instr;
  logic        rand_ready;
  modport master (
    output instr_req, instr_addr, rand_valid, rand_instr,
    input  instr_gnt, instr_rvalid, instr_rdata, instr_err, rand_ready
  );
  modport slave (
    input  instr_req, instr_addr, rand_valid, rand_instr,
    output instr_gnt, instr_rvalid, instr_rdata, instr_err, rand_ready
  );
endinterface

// File: rtl/ibex_stim_phase_ctrl.sv
// ibex_stim_phase_ctrl: FLUSH / (BURST, DRAIN) x NUM_ITER fetch sequencer counting granted fetches.
// Define IBEX_STIM_STARVE_TIMEOUT_EN to substitute a NOP after MAX_WAIT starved BURST cycles.
module ibex_stim_phase_ctrl #(
  parameter int FLUSH_FETCHES = 100,
  parameter int BURST_FETCHES = 64,
  parameter int DRAIN_FETCHES = 16,
  parameter int NUM_ITER      = 4,
  parameter int MAX_WAIT      = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  ibex_stim_phase_ctrl_if.slave       bus,
  output logic [2:0]                  phase_o,
  output logic [15:0]                 iter_o,
  output logic                        done_o,
  output logic [15:0]                 starve_cnt_o
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [2:0] {IDLE, FLUSH, BURST, DRAIN, DONE} state_e;
  state_e      state_q, state_d;
  logic [31:0] cnt_q, rdata_q, lim;
  logic [15:0] iter_q;
  logic        rvalid_q, timeout, last;
  logic        unused_ok;
`ifdef IBEX_STIM_STARVE_TIMEOUT_EN
  logic [15:0] wait_q, starve_q;
  assign timeout = wait_q == 16'(MAX_WAIT) && !bus.rand_valid;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q   <= '0;
      starve_q <= '0;
    end else begin
      wait_q <= (state_q == BURST && state_d == BURST && bus.instr_req && !bus.instr_gnt) ? wait_q + 16'd1 : '0;
      if (state_q == BURST && bus.instr_gnt && !bus.rand_valid && starve_q != 16'hFFFF) starve_q <= starve_q + 16'd1;
    end
  end
  assign starve_cnt_o = starve_q;
`else
  assign timeout      = 1'b0;
  assign starve_cnt_o = '0;
`endif
  // Grant is forced low during reset; only BURST can stall on the random source.
  assign bus.instr_gnt  = !rst_i && bus.instr_req && (state_q != BURST || bus.rand_valid || timeout);
  assign bus.rand_ready = state_q == BURST && bus.instr_req;
  assign lim  = state_q == FLUSH ? 32'(FLUSH_FETCHES - 1) : state_q == BURST ? 32'(BURST_FETCHES - 1) : 32'(DRAIN_FETCHES - 1);
  assign last = bus.instr_gnt && cnt_q == lim;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = start_i ? FLUSH : IDLE;
    else if (last) state_d = state_q == FLUSH ? BURST : state_q == BURST ? DRAIN : state_q == DRAIN ? (iter_q < 16'(NUM_ITER - 1) ? BURST : DONE) : state_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      iter_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= NOP;
    end else begin
      state_q  <= state_d;
      cnt_q    <= state_d != state_q ? '0 : cnt_q + 32'(bus.instr_gnt);
      iter_q   <= iter_q + 16'(state_q == DRAIN && state_d == BURST);
      rvalid_q <= bus.instr_gnt;
      if (bus.instr_gnt) rdata_q <= (state_q == BURST && bus.rand_valid) ? bus.rand_instr : NOP;
    end
  end
  assign bus.instr_rvalid = rvalid_q;
  assign bus.instr_rdata  = rdata_q;
  assign bus.instr_err    = 1'b0;
  assign phase_o          = state_q;
  assign iter_o           = iter_q;
  assign done_o           = state_q == DONE;
  assign unused_ok        = ^{bus.instr_addr, 32'(MAX_WAIT)};
endmodule

// File: tb/tb_ibex_stim_phase_ctrl.sv
// tb_ibex_stim_phase_ctrl: random and directed fetch traffic checked against a phase-schedule model.
module tb_ibex_stim_phase_ctrl;
  localparam int FL = 4, BU = 3, DR = 2, NI = 2, MW = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
  logic [2:0]  phase_o;
  logic [15:0] iter_o, starve_cnt_o;
  logic        done_o;
  ibex_stim_phase_ctrl_if bus();
  ibex_stim_phase_ctrl #(.FLUSH_FETCHES(FL), .BURST_FETCHES(BU), .DRAIN_FETCHES(DR), .NUM_ITER(NI), .MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .bus(bus),
    .phase_o(phase_o), .iter_o(iter_o), .done_o(done_o), .starve_cnt_o(starve_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  int          sph[$], slim[$];
  int          idx, nf, mwait, mstarve, n_chk, n_pass;
  logic        mrv;
  logic [31:0] mrd;
  logic [31:0] seen[$];
  logic [31:0] tbl[14];
  function automatic int mphase();
    return idx < 0 ? 0 : idx >= sph.size() ? 4 : sph[idx];
  endfunction
  function automatic int miter();
    return idx <= 0 ? 0 : idx >= sph.size() ? NI - 1 : (idx - 1) / 2;
  endfunction
  function automatic void mreset();
    idx = -1; nf = 0; mwait = 0; mstarve = 0; mrv = 1'b0; mrd = NOP;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step(input logic st, input logic req, input logic val, input logic [31:0] w, output logic cons);
    logic eg, to;
    int ph;
    @(negedge clk_i);
    start_i = st; bus.instr_req = req; bus.rand_valid = val; bus.rand_instr = w; bus.instr_addr = $urandom;
    #1;
    ph = mphase();
`ifdef IBEX_STIM_STARVE_TIMEOUT_EN
    to = mwait == MW && !val;
`else
    to = 1'b0;
`endif
    eg = req && (ph != 2 || val || to);
    if (bus.instr_rvalid) seen.push_back(bus.instr_rdata);
    check("gnt", 32'(bus.instr_gnt), 32'(eg));
    check("ready", 32'(bus.rand_ready), 32'(ph == 2 && req));
    check("rvalid", 32'(bus.instr_rvalid), 32'(mrv));
    check("rdata", bus.instr_rdata, mrd);
    check("phase", 32'(phase_o), 32'(ph));
    check("iter", 32'(iter_o), 32'(miter()));
    check("done", 32'(done_o), 32'(ph == 4));
    check("starve", 32'(starve_cnt_o), 32'(mstarve));
    check("err", 32'(bus.instr_err), 32'd0);
    cons = ph == 2 && eg && val;
    mrv = eg;
    if (eg) mrd = cons ? w : NOP;
    if (ph == 2 && eg && !val && mstarve < 65535) mstarve++;
    mwait = (ph == 2 && req && !val && !eg) ? mwait + 1 : 0;
    if (ph == 0) begin
      if (st) begin idx = 0; nf = 0; end
    end else if (ph != 4 && eg) begin
      nf++;
      if (nf == slim[idx]) begin idx++; nf = 0; mwait = 0; end
    end
  endtask
  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1; start_i = 1'b0; bus.instr_req = 1'b1; bus.rand_valid = 1'b1;
    #1;
    check("rst_gnt", 32'(bus.instr_gnt), 32'd0);
    check("rst_rvalid", 32'(bus.instr_rvalid), 32'd0);
    check("rst_rdata", bus.instr_rdata, NOP);
    check("rst_phase", 32'(phase_o), 32'd0);
    check("rst_iter", 32'(iter_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_starve", 32'(starve_cnt_o), 32'd0);
    check("rst_ready", 32'(bus.rand_ready), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; bus.instr_req = 1'b0;
    mreset();
  endtask
  task automatic reach_burst();
    logic c;
    int n = 0;
    step(1'b1, 1'b0, 1'b0, 32'd0, c);
    while (mphase() != 2 && n < 50) begin step(1'b0, 1'b1, 1'b1, $urandom, c); n++; end
    step(1'b0, 1'b0, 1'b0, 32'd0, c);
    check("in_burst", 32'(phase_o), 32'd2);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic c;
    logic [31:0] nxt;
    int g, n, vp;
    n_chk = 0; n_pass = 0;
    bus.instr_req = 1'b0; bus.rand_valid = 1'b0; bus.rand_instr = '0; bus.instr_addr = '0;
    sph.push_back(1); slim.push_back(FL);
    for (int i = 0; i < NI; i++) begin
      sph.push_back(2); slim.push_back(BU);
      sph.push_back(3); slim.push_back(DR);
    end
    tbl = '{NOP, NOP, NOP, NOP, 32'd1, 32'd2, 32'd3, NOP, NOP, 32'd4, 32'd5, 32'd6, NOP, NOP};
    mreset();
    do_reset();
    // Full run with a counting random source and the returned-word sequence compared to a fixed table.
    seen.delete();
    nxt = 32'd1;
    step(1'b1, 1'b0, 1'b1, nxt, c);
    repeat (20) begin
      step(1'b0, 1'b1, 1'b1, nxt, c);
      if (c) nxt++;
    end
    check("seen_n", 32'(seen.size() >= 14), 32'd1);
    for (int i = 0; i < 14 && i < seen.size(); i++) check($sformatf("seq%0d", i), seen[i], tbl[i]);
    check("full_done", 32'(done_o), 32'd1);
    // Backpressure then starvation inside one BURST.
    do_reset();
    reach_burst();
    g = 0;
    repeat (5) begin step(1'b0, 1'b1, 1'b0, $urandom, c); g += int'(bus.instr_gnt); end
    check("bp_gnt", 32'(g), 32'd0);
    step(1'b0, 1'b1, 1'b1, $urandom, c);
    check("bp_first_valid", 32'(bus.instr_gnt), 32'd1);
    g = 0;
`ifdef IBEX_STIM_STARVE_TIMEOUT_EN
    repeat (9) begin step(1'b0, 1'b1, 1'b0, $urandom, c); g += int'(bus.instr_gnt); end
    check("starve_gnt", 32'(g), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, c);
    check("starve_cnt", 32'(starve_cnt_o), 32'd1);
`else
    repeat (1000) begin step(1'b0, 1'b1, 1'b0, $urandom, c); g += int'(bus.instr_gnt); end
    check("starve_gnt", 32'(g), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, c);
    check("starve_cnt", 32'(starve_cnt_o), 32'd0);
`endif
    // Reset while a BURST grant's rvalid is pending.
    do_reset();
    reach_burst();
    step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, c);
    @(posedge clk_i); #1;
    check("pre_rst_rvalid", 32'(bus.instr_rvalid), 32'd1);
    check("pre_rst_rdata", bus.instr_rdata, 32'hDEAD_BEEF);
    do_reset();
    // Random runs with request gaps, source stalls and stray start pulses.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      vp = $urandom_range(20, 100);
      n = 0;
      while (mphase() != 4 && n < 3000) begin
        step($urandom % 8 == 0, $urandom % 4 != 0, $urandom % 100 < vp, $urandom, c);
        n++;
      end
      repeat (3) step($urandom % 2 == 0, $urandom % 2 == 0, $urandom % 2 == 0, $urandom, c);
      check($sformatf("run%0d_done", r), 32'(done_o), 32'd1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ibex_stim_phase_ctrl.md
# ibex_stim_phase_ctrl

Phase sequencer for the Ibex stimulus bench. It sits between the core's instruction-fetch port and a constrained-random instruction source, and it sequences each run: one NOP flush window, then NUM_ITER iterations of a random burst followed by a NOP drain. It counts granted fetches rather than cycles, so phases are independent of core stalls, and it reports progress and completion to the bench.

## Interface
- FLUSH_FETCHES, 100: NOP fetches granted in FLUSH (≥1)
- BURST_FETCHES, 64: fetches per BURST (≥1)
- DRAIN_FETCHES, 16: NOP fetches per DRAIN (≥1)
- NUM_ITER, 4: BURST/DRAIN iterations (1..65535)
- MAX_WAIT, 8: starvation limit in cycles (≥1), used only when the starvation timeout is compiled in
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  pulse; starts a run from IDLE
- instr_req_i  in  1  core fetch request
- instr_addr_i  in  32  fetch address; used for the trace only
- instr_gnt_o  out  1  fetch grant
- instr_rvalid_o  out  1  fetch data valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  always 0
- rand_valid_i  in  1  random source has an instruction
- rand_instr_i  in  32  random instruction word
- rand_ready_o  out  1  controller consumes rand_instr_i this cycle when rand_valid_i is high
- phase_o  out  3  IDLE=0, FLUSH=1, BURST=2, DRAIN=3, DONE=4
- iter_o  out  16  index of the current iteration
- done_o  out  1  high in DONE
- starve_cnt_o  out  16  number of NOPs substituted for starvation; saturates at 0xFFFF

## Operation
- States: IDLE → (start_i) → FLUSH → BURST → DRAIN → BURST … → DONE. DONE exits only on reset.
- A fetch is a cycle with instr_req_i && instr_gnt_o. A 32-bit fetch counter clears on every state change.
- IDLE, FLUSH, DRAIN, DONE:
  - instr_gnt_o = instr_req_i; returned data is NOP 0x00000013.
  - rand_ready_o = 0.
- BURST:
  - rand_ready_o = instr_req_i.
  - instr_gnt_o = instr_req_i && (rand_valid_i || timeout).
  - Returned data is rand_instr_i when rand_valid_i, otherwise NOP.
- Transitions occur on the fetch that brings the counter to the phase limit:
  - FLUSH → BURST after FLUSH_FETCHES fetches.
  - BURST → DRAIN after BURST_FETCHES fetches.
  - DRAIN → BURST after DRAIN_FETCHES fetches, with iter_o incremented, if iter_o < NUM_ITER-1.
  - DRAIN → DONE otherwise.
- start_i outside IDLE is ignored. instr_addr_i has no effect on sequencing.
- Starvation timeout (macro only):
  - A wait counter increments on each BURST cycle with instr_req_i && !rand_valid_i.
  - It clears on any grant, on instr_req_i low, or on a state change.
  - When the wait counter equals MAX_WAIT and rand_valid_i is low: grant, return NOP, increment starve_cnt_o. The substituted NOP counts as a burst fetch.

## Timing
- Grant is combinational from the same-cycle request and state.
- instr_rvalid_o rises exactly 1 cycle after each grant.
- instr_rdata_o is registered at grant time and held until the next grant. Back-to-back fetches give rvalid on consecutive cycles.
- Phase, iter and done outputs update 1 cycle after the transition fetch. The first fetch of the new phase may occur in that next cycle.
- Last BURST fetch coincident with rand_valid_i: the word is consumed and returned, and the state becomes DRAIN.
- Reset values: instr_gnt_o=0 (forced while rst_i=1), instr_rvalid_o=0, instr_rdata_o=0x00000013, instr_err_o=0, rand_ready_o=0, phase_o=0, iter_o=0, done_o=0, starve_cnt_o=0.
- Reset mid-run: all state clears immediately, and any pending rvalid is dropped.

## Configuration
- IBEX_STIM_STARVE_TIMEOUT_EN defined: the MAX_WAIT timeout substitutes a NOP and counts it in starve_cnt_o.
- IBEX_STIM_STARVE_TIMEOUT_EN undefined: BURST waits indefinitely for rand_valid_i, starve_cnt_o is tied to 0, and the wait counter is not built.

## Test plan
- Flush count: reset, pulse start_i, hold instr_req_i=1, tie rand_valid_i=1 → exactly 100 rvalids carrying 0x00000013, then phase_o=2 on the cycle after fetch 100.
- Full run: FLUSH_FETCHES=4, BURST_FETCHES=3, DRAIN_FETCHES=2, NUM_ITER=2, rand_instr_i counting 1, 2, 3 … →
  - rdata sequence: NOP×4, 1, 2, 3, NOP×2, 4, 5, 6, NOP×2.
  - done_o=1; iter_o is 0 during iteration 0 and 1 during iteration 1.
- Source backpressure: rand_valid_i low for 5 cycles in BURST, macro defined, MAX_WAIT=8 → no grant for 5 cycles, then grant on the first valid; starve_cnt_o=0.
- Starvation: rand_valid_i held low, MAX_WAIT=8, macro defined → a NOP is granted on the 9th requesting cycle and starve_cnt_o=1. With the macro undefined → no grant after 1000 cycles.
- Reset mid-BURST: assert rst_i on a grant cycle → rvalid_o=0 on the next edge, phase_o=0, iter_o=0, rdata=0x00000013. A start_i pulse issued while phase_o≠0 is ignored.
- Request gaps: instr_req_i toggling 1,0,1,0 in DRAIN → only granted cycles count, and the transition occurs after DRAIN_FETCHES grants, not after DRAIN_FETCHES cycles.
